// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the SRAM-like port arbiter.
// Owner encoding and request bundle layout.
package sram_req_arbiter_pkg;

    localparam int SIZE_W  = 2;
    localparam int WSTRB_W = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;

    typedef enum logic {
        OWNER_INST = 1'b0,
        OWNER_DATA = 1'b1
    } owner_e;

    typedef struct packed {
        logic               wr;
        logic [SIZE_W-1:0]  size;
        logic [WSTRB_W-1:0] wstrb;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_req_arbiter_tag_fifo.sv
// In-order owner tag FIFO, 1-bit payload.
// Push and pop may coincide, including on an empty FIFO.
module tag_fifo #(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          din,
    output logic          dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] mem_q;
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             push_e, pop_e;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign dout  = mem_q[rd_q];

    // Qualify requests and compute next pointers and occupancy.
    always_comb begin
        pop_e  = pop & ~empty;
        push_e = push & (~full | pop_e);
        wr_d   = push_e ? wr_q + AW'(1) : wr_q;
        rd_d   = pop_e ? rd_q + AW'(1) : rd_q;
        cnt_d  = cnt_q;
        if (push_e && !pop_e) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_e && pop_e) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Tag storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push_e) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Arbitrates inst/data SRAM-like requesters onto one bridge port
// and steers responses back using an in-order owner tag FIFO.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               inst_sram_req,
    input  logic               inst_sram_wr,
    input  logic [SIZE_W-1:0]  inst_sram_size,
    input  logic [WSTRB_W-1:0] inst_sram_wstrb,
    input  logic [ADDR_W-1:0]  inst_sram_addr,
    input  logic [DATA_W-1:0]  inst_sram_wdata,
    output logic               inst_sram_addr_ok,
    output logic               inst_sram_data_ok,
    output logic [DATA_W-1:0]  inst_sram_rdata,
    input  logic               data_sram_req,
    input  logic               data_sram_wr,
    input  logic [SIZE_W-1:0]  data_sram_size,
    input  logic [WSTRB_W-1:0] data_sram_wstrb,
    input  logic [ADDR_W-1:0]  data_sram_addr,
    input  logic [DATA_W-1:0]  data_sram_wdata,
    output logic               data_sram_addr_ok,
    output logic               data_sram_data_ok,
    output logic [DATA_W-1:0]  data_sram_rdata,
    output logic               mem_req,
    output logic               mem_wr,
    output logic [SIZE_W-1:0]  mem_size,
    output logic [WSTRB_W-1:0] mem_wstrb,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic               mem_addr_ok,
    input  logic               mem_data_ok,
    input  logic [DATA_W-1:0]  mem_rdata,
    output logic               arb_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic          hold_q, hold_d;
    owner_e        hold_own_q, hold_own_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          arb_err_q, arb_err_d;

    logic          fifo_full, fifo_empty, tag_dout;
    logic [CW-1:0] fifo_count;
    logic          gnt_vld, force_inst, push, pop;
    owner_e        gnt_own, tag_own;
    sram_req_t     inst_r, data_r, mux_r;

    assign inst_r = '{inst_sram_wr, inst_sram_size, inst_sram_wstrb,
                      inst_sram_addr, inst_sram_wdata};
    assign data_r = '{data_sram_wr, data_sram_size, data_sram_wstrb,
                      data_sram_addr, data_sram_wdata};

    // Grant selection: held owner first, then starvation, then data.
    always_comb begin
        gnt_vld    = 1'b0;
        gnt_own    = OWNER_INST;
        force_inst = (starve_q == SW'(STARVE_LIMIT));
        if (!rst && !fifo_full) begin
            if (hold_q && hold_own_q == OWNER_DATA && data_sram_req) begin
                gnt_vld = 1'b1;
                gnt_own = OWNER_DATA;
            end else if (hold_q && hold_own_q == OWNER_INST && inst_sram_req) begin
                gnt_vld = 1'b1;
                gnt_own = OWNER_INST;
            end else if (force_inst && inst_sram_req) begin
                gnt_vld = 1'b1;
                gnt_own = OWNER_INST;
            end else if (data_sram_req) begin
                gnt_vld = 1'b1;
                gnt_own = OWNER_DATA;
            end else if (inst_sram_req) begin
                gnt_vld = 1'b1;
                gnt_own = OWNER_INST;
            end
        end
    end

    // Request mux toward the bridge; zero when idle.
    always_comb begin
        mux_r = '0;
        if (gnt_vld) begin
            mux_r = (gnt_own == OWNER_DATA) ? data_r : inst_r;
        end
    end

    assign mem_req   = gnt_vld;
    assign mem_wr    = mux_r.wr;
    assign mem_size  = mux_r.size;
    assign mem_wstrb = mux_r.wstrb;
    assign mem_addr  = mux_r.addr;
    assign mem_wdata = mux_r.wdata;

    assign push    = mem_req & mem_addr_ok;
    assign pop     = ~rst & mem_data_ok & ~fifo_empty;
    assign tag_own = owner_e'(tag_dout);

    assign inst_sram_addr_ok = push & (gnt_own == OWNER_INST);
    assign data_sram_addr_ok = push & (gnt_own == OWNER_DATA);
    assign inst_sram_data_ok = pop & (tag_own == OWNER_INST);
    assign data_sram_data_ok = pop & (tag_own == OWNER_DATA);
    assign inst_sram_rdata   = rst ? '0 : mem_rdata;
    assign data_sram_rdata   = rst ? '0 : mem_rdata;
    assign arb_err           = arb_err_q & ~rst;

    // Next hold, starvation and error state.
    always_comb begin
        hold_d     = mem_req & ~mem_addr_ok;
        hold_own_d = gnt_own;
        starve_d   = '0;
        if (inst_sram_req && !inst_sram_addr_ok) begin
            starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q
                                                        : starve_q + SW'(1);
        end
        arb_err_d = arb_err_q | (mem_data_ok & (fifo_count == '0));
    end

    // Arbiter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q     <= 1'b0;
            hold_own_q <= OWNER_INST;
            starve_q   <= '0;
            arb_err_q  <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_own_q <= hold_own_d;
            starve_q   <= starve_d;
            arb_err_q  <= arb_err_d;
        end
    end

    tag_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (logic'(gnt_own)),
        .dout  (tag_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Scoreboard bench for sram_req_arbiter.
// Expected owners are queued on acceptance and popped on mem_data_ok.
module tb_sram_req_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_sram_req = 1'b0;
    logic        inst_sram_wr = 1'b0;
    logic [1:0]  inst_sram_size = 2'd2;
    logic [3:0]  inst_sram_wstrb = 4'h0;
    logic [31:0] inst_sram_addr = 32'h1c000000;
    logic [31:0] inst_sram_wdata = 32'hdeadbeef;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req = 1'b0;
    logic        data_sram_wr = 1'b1;
    logic [1:0]  data_sram_size = 2'd1;
    logic [3:0]  data_sram_wstrb = 4'hc;
    logic [31:0] data_sram_addr = 32'h80001000;
    logic [31:0] data_sram_wdata = 32'h12345678;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        mem_req, mem_wr;
    logic [1:0]  mem_size;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok = 1'b0;
    logic        mem_data_ok = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        arb_err;

    int n_chk = 0;
    int n_fail = 0;
    bit sb_q[$];
    bit exp_err = 1'b0;

    always #5 clk = ~clk;

    sram_req_arbiter #(
        .MAX_OUTSTANDING (4),
        .STARVE_LIMIT    (8)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_wstrb   (inst_sram_wstrb),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_size    (data_sram_size),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .mem_req           (mem_req),
        .mem_wr            (mem_wr),
        .mem_size          (mem_size),
        .mem_wstrb         (mem_wstrb),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_addr_ok       (mem_addr_ok),
        .mem_data_ok       (mem_data_ok),
        .mem_rdata         (mem_rdata),
        .arb_err           (arb_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            rst = 1'b1;
            inst_sram_req = 1'b1;
            data_sram_req = 1'b1;
            mem_addr_ok = 1'b1;
            mem_data_ok = 1'b1;
            mem_rdata = 32'h5a5a5a5a;
            #2;
            chk("rst_mem_req", 32'(mem_req), 32'd0);
            chk("rst_mem_addr", mem_addr, 32'd0);
            chk("rst_i_aok", 32'(inst_sram_addr_ok), 32'd0);
            chk("rst_d_aok", 32'(data_sram_addr_ok), 32'd0);
            chk("rst_i_dok", 32'(inst_sram_data_ok), 32'd0);
            chk("rst_d_dok", 32'(data_sram_data_ok), 32'd0);
            chk("rst_i_rdata", inst_sram_rdata, 32'd0);
            chk("rst_arb_err", 32'(arb_err), 32'd0);
        end
        sb_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic step(input bit ir, input bit dr, input bit aok,
                        input bit dok, input logic [31:0] rd,
                        input bit e_req, input bit e_own);
        bit own;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inst_sram_req = ir;
        data_sram_req = dr;
        mem_addr_ok = aok;
        mem_data_ok = dok;
        mem_rdata = rd;
        #2;
        chk("arb_err", 32'(arb_err), 32'(exp_err));
        chk("mem_req", 32'(mem_req), 32'(e_req));
        chk("inst_addr_ok", 32'(inst_sram_addr_ok), 32'(e_req & aok & !e_own));
        chk("data_addr_ok", 32'(data_sram_addr_ok), 32'(e_req & aok & e_own));
        if (e_req) begin
            chk("mem_addr", mem_addr, e_own ? data_sram_addr : inst_sram_addr);
            chk("mem_wdata", mem_wdata, e_own ? data_sram_wdata : inst_sram_wdata);
            chk("mem_ctl", 32'({mem_wr, mem_size, mem_wstrb}),
                e_own ? 32'({data_sram_wr, data_sram_size, data_sram_wstrb})
                      : 32'({inst_sram_wr, inst_sram_size, inst_sram_wstrb}));
        end else begin
            chk("mem_addr_idle", mem_addr, 32'd0);
        end
        if (dok && sb_q.size() > 0) begin
            own = sb_q.pop_front();
            chk("inst_data_ok", 32'(inst_sram_data_ok), 32'(!own));
            chk("data_data_ok", 32'(data_sram_data_ok), 32'(own));
            chk("inst_rdata", inst_sram_rdata, rd);
            chk("data_rdata", data_sram_rdata, rd);
        end else begin
            chk("inst_data_ok_0", 32'(inst_sram_data_ok), 32'd0);
            chk("data_data_ok_0", 32'(data_sram_data_ok), 32'd0);
            if (dok) exp_err = 1'b1;
        end
        if (e_req && aok) sb_q.push_back(e_own);
    endtask

    initial begin
        do_reset(2);

        // single inst read, data_ok two cycles later
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 1, 32'h02800000, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0);

        // simultaneous requests: data first, then inst
        do_reset(1);
        step(1, 1, 1, 0, 32'h0, 1, 1);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(0, 0, 0, 1, 32'h0000d00d, 0, 0);
        step(0, 0, 0, 1, 32'h00001111, 0, 0);

        // data stalled three cycles, inst arrives mid-stall
        do_reset(1);
        step(0, 1, 0, 0, 32'h0, 1, 1);
        step(1, 1, 0, 0, 32'h0, 1, 1);
        step(1, 1, 0, 0, 32'h0, 1, 1);
        step(1, 1, 1, 0, 32'h0, 1, 1);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(0, 0, 0, 1, 32'haaaa0001, 0, 0);
        step(0, 0, 0, 1, 32'haaaa0002, 0, 0);

        // inst stalled, data arrives: grant must not switch
        do_reset(1);
        step(1, 0, 0, 0, 32'h0, 1, 0);
        step(1, 1, 0, 0, 32'h0, 1, 0);
        step(1, 1, 1, 0, 32'h0, 1, 0);
        step(0, 1, 1, 0, 32'h0, 1, 1);
        step(0, 0, 0, 1, 32'hbbbb0001, 0, 0);
        step(0, 0, 0, 1, 32'hbbbb0002, 0, 0);

        // fill to MAX_OUTSTANDING, pop reopens one cycle later
        do_reset(1);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 32'h0, 1, 1);
        step(0, 1, 1, 0, 32'h0, 0, 1);
        step(0, 1, 1, 1, 32'hcccc0001, 0, 1);
        step(0, 1, 1, 0, 32'h0, 1, 1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 32'hcccc0010 + 32'(i), 0, 0);

        // starvation: inst wins once every nine grants
        do_reset(1);
        for (int i = 0; i < 27; i++)
            step(1, 1, 1, i > 0, 32'h100 + 32'(i), 1, (i % 9) != 8);
        step(0, 0, 0, 1, 32'h200, 0, 0);

        // orphan response sets sticky error
        do_reset(1);
        step(0, 0, 0, 1, 32'hee, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0);

        // reset with two tags outstanding discards them
        do_reset(1);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(0, 1, 1, 0, 32'h0, 1, 1);
        do_reset(1);
        step(0, 0, 0, 0, 32'h0, 0, 0);
        step(0, 0, 0, 1, 32'hff, 0, 0);
        step(0, 0, 0, 0, 32'h0, 0, 0);
        step(1, 0, 1, 0, 32'h0, 1, 0);
        step(0, 0, 0, 1, 32'h77, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
